// File: rtl/raw_stream_gen_pkg.sv
// Shared types and constants for the raw_stream_gen test-pattern source.
// Holds the FSM/pattern enums, default timing and the LFSR seed/tap constants.
package raw_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_CONST = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_AUX   = 2'd3
    } pattern_t;

    localparam int unsigned DEF_H_ACTIVE = 1280;
    localparam int unsigned DEF_V_ACTIVE = 960;
    localparam int unsigned DEF_H_BLANK  = 16;
    localparam int unsigned DEF_V_BLANK  = 4;

    // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/raw_stream_gen_lfsr.sv
// 16-bit Fibonacci LFSR with seed load and advance enable; only built with
// RAW_STREAM_GEN_LFSR_EN. next_low_o is the value the register takes at this edge.
`ifdef RAW_STREAM_GEN_LFSR_EN
module raw_lfsr16
    import raw_stream_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        en,
    input  logic        load,
    output logic [11:0] next_low_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = LFSR_SEED;
        end else if (en) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign next_low_o = state_d[11:0];

endmodule
`endif

// File: rtl/raw_stream_gen.sv
// Raw 12-bit video test-pattern generator with line/frame blanking and frame_done pulse.
// Build option RAW_STREAM_GEN_LFSR_EN: pattern 3 becomes an LFSR stream instead of a checkerboard.
module raw_stream_gen
    import raw_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned H_BLANK  = DEF_H_BLANK,
    parameter int unsigned V_BLANK  = DEF_V_BLANK
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iCONT,
    input  logic [1:0]  iPATTERN,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oFRAME_DONE,
    output logic        oBUSY
);

    localparam int unsigned VB_CYC = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int          CW     = $clog2(VB_CYC + H_BLANK + 2);

    localparam logic [10:0]   H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0]   V_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VB_LAST = CW'(VB_CYC - 1);
    // cnt == VB_END marks the frame_done cycle before a continuous restart.
    localparam logic [CW-1:0] VB_END  = CW'(VB_CYC);

    state_t        state_q, state_d;
    pattern_t      pat_q, pat_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   data_q, data_d;
    logic          dval_q, dval_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic          frame_start;
    logic          line_end;
    logic          lines_done;
    logic          frame_end;
    logic [11:0]   pix;

`ifdef RAW_STREAM_GEN_LFSR_EN
    logic [11:0] lfsr_low;

    raw_lfsr16 u_lfsr (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .en         (dval_d),
        .load       (frame_start),
        .next_low_o (lfsr_low)
    );
`endif

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        frame_start = 1'b0;
        line_end    = 1'b0;
        lines_done  = 1'b0;
        frame_end   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (iSTART) frame_start = 1'b1;
            end
            ST_ACTIVE: begin
                if (x_q == H_LAST) begin
                    if (H_BLANK == 0) begin
                        line_end = 1'b1;
                    end else begin
                        state_d = ST_HBLANK;
                        cnt_d   = '0;
                    end
                end else begin
                    x_d = x_q + 11'd1;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) line_end = 1'b1;
                else                  cnt_d    = cnt_q + 1'b1;
            end
            ST_VBLANK: begin
                if (cnt_q == VB_END)       frame_start = 1'b1;
                else if (cnt_q == VB_LAST) frame_end   = 1'b1;
                else                       cnt_d       = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Zero-length blanking intervals collapse straight into the next step.
        if (line_end) begin
            if (y_q == V_LAST) begin
                lines_done = 1'b1;
            end else begin
                state_d = ST_ACTIVE;
                x_d     = '0;
                y_d     = y_q + 11'd1;
            end
        end
        if (lines_done) begin
            if (VB_CYC == 0) begin
                frame_end = 1'b1;
            end else begin
                state_d = ST_VBLANK;
                cnt_d   = '0;
            end
        end
        if (frame_end) begin
            done_d = 1'b1;
            if (iCONT) begin
                state_d = ST_VBLANK;
                cnt_d   = VB_END;
            end else begin
                state_d = ST_IDLE;
            end
        end
        if (frame_start) begin
            state_d = ST_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            pat_d   = pattern_t'(iPATTERN);
        end

        unique case (pat_d)
            PAT_CONST: pix = 12'h800;
            PAT_RAMP:  pix = {x_d, 1'b0};
            PAT_BARS:  pix = x_d[6] ? 12'hFFF : 12'h000;
`ifdef RAW_STREAM_GEN_LFSR_EN
            default:   pix = lfsr_low;
`else
            default:   pix = (x_d[3] ^ y_d[3]) ? 12'hFFF : 12'h000;
`endif
        endcase

        dval_d = (state_d == ST_ACTIVE);
        data_d = dval_d ? pix : 12'h000;
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_CONST;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            dval_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dval_q  <= dval_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFRAME_DONE = done_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_raw_stream_gen.sv
// Directed bench for raw_stream_gen: small-frame timing on one instance, zero-blank
// wide-line patterns on a second. Pattern-3 expectations follow RAW_STREAM_GEN_LFSR_EN.
module tb_raw_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_cont, b_start, b_cont;
    logic [1:0]  a_pat, b_pat;
    logic [11:0] a_data, b_data;
    logic        a_dval, b_dval, a_done, b_done, a_busy, b_busy;
    logic [10:0] a_x, a_y, b_x, b_y;

    int n_tests = 0;
    int n_fail  = 0;
    int nbeats;
    logic exp_v;

    raw_stream_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(2), .V_BLANK(1)) dut_a (
        .iCLK(clk), .iRST(rst), .iSTART(a_start), .iCONT(a_cont), .iPATTERN(a_pat),
        .oDATA(a_data), .oDVAL(a_dval), .oX_Cont(a_x), .oY_Cont(a_y),
        .oFRAME_DONE(a_done), .oBUSY(a_busy)
    );

    raw_stream_gen #(.H_ACTIVE(128), .V_ACTIVE(2), .H_BLANK(0), .V_BLANK(0)) dut_b (
        .iCLK(clk), .iRST(rst), .iSTART(b_start), .iCONT(b_cont), .iPATTERN(b_pat),
        .oDATA(b_data), .oDVAL(b_dval), .oX_Cont(b_x), .oY_Cont(b_y),
        .oFRAME_DONE(b_done), .oBUSY(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic dv, input int x, input int y,
                           input int d);
        check({tag, "_dval"}, a_dval, dv);
        check({tag, "_x"}, a_x, x);
        check({tag, "_y"}, a_y, y);
        check({tag, "_data"}, a_data, d);
    endtask

    task automatic check_b(input string tag, input int x, input int y, input int d);
        check({tag, "_dval"}, b_dval, 1);
        check({tag, "_x"}, b_x, x);
        check({tag, "_y"}, b_y, y);
        check({tag, "_data"}, b_data, d);
    endtask

    initial begin
        logic [11:0] lfsr_exp [4];
        lfsr_exp[0] = 12'hCE1;
        lfsr_exp[1] = 12'h670;
        lfsr_exp[2] = 12'hB38;
        lfsr_exp[3] = 12'h59C;

        rst = 1'b1;
        a_start = 1'b0; a_cont = 1'b0; a_pat = 2'd1;
        b_start = 1'b0; b_cont = 1'b0; b_pat = 2'd2;
        tick(3);
        check_a("reset", 0, 0, 0, 0);
        check("reset_done", a_done, 0);
        check("reset_busy", a_busy, 0);

        // Single frame, ramp pattern; start asserted on the first edge out of reset.
        rst = 1'b0;
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        nbeats = 0;
        for (int c = 0; c < 50; c++) begin
            exp_v = (c < 40) && ((c % 10) < 8);
            check("f1_dval", a_dval, exp_v);
            if (exp_v) begin
                nbeats++;
                check_a("f1_beat", 1, c % 10, c / 10, 2 * (c % 10));
            end
            check("f1_done_early", a_done, 0);
            check("f1_busy", a_busy, 1);
            a_start = (c == 20);
            tick(1);
        end
        check("f1_beats", nbeats, 32);
        check("f1_done", a_done, 1);
        check("f1_done_busy", a_busy, 0);
        check("f1_done_dval", a_dval, 0);
        tick(1);
        check("f1_done_pulse", a_done, 0);
        tick(5);
        check("f1_idle_busy", a_busy, 0);
        check_a("f1_idle", 0, 7, 3, 0);

        // Continuous mode with a mid-frame pattern change, then continuous mode dropped.
        a_cont = 1'b1;
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        check_a("c_f1_first", 1, 0, 0, 0);
        tick(50);
        check("c_done", a_done, 1);
        check("c_done_dval", a_dval, 0);
        check("c_done_busy", a_busy, 1);
        tick(1);
        check_a("c_f2_first", 1, 0, 0, 0);
        check("c_f2_done", a_done, 0);
        tick(15);
        a_pat = 2'd2;
        tick(22);
        check_a("c_f2_last_ramp", 1, 7, 3, 14);
        tick(14);
        check_a("c_f3_bars", 1, 0, 0, 0);
        tick(1);
        check_a("c_f3_bars_x1", 1, 1, 0, 0);
        a_cont = 1'b0;
        tick(49);
        check("c_f3_done", a_done, 1);
        check("c_f3_busy", a_busy, 0);
        tick(1);
        check("c_f3_idle_dval", a_dval, 0);
        check("c_f3_idle_busy", a_busy, 0);

        // Reset mid-frame at beat 13, then restart on the first edge out of reset.
        a_pat = 2'd1;
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        tick(15);
        check_a("r_beat13", 1, 5, 1, 10);
        rst = 1'b1;
        tick(1);
        check_a("r_after", 0, 0, 0, 0);
        check("r_after_done", a_done, 0);
        check("r_after_busy", a_busy, 0);
        rst = 1'b0;
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        check_a("r_restart", 1, 0, 0, 0);
        check("r_restart_busy", a_busy, 1);
        tick(1);
        check_a("r_restart_x1", 1, 1, 0, 2);
        tick(49);
        check("r_done", a_done, 1);

        // Wide lines, no blanking: bars, back-to-back lines and frames.
        b_cont = 1'b1;
        b_start = 1'b1;
        tick(1);
        b_start = 1'b0;
        check_b("b_x0", 0, 0, 12'h000);
        tick(63);
        check_b("b_x63", 63, 0, 12'h000);
        tick(1);
        check_b("b_x64", 64, 0, 12'hFFF);
        tick(63);
        check_b("b_x127", 127, 0, 12'hFFF);
        tick(1);
        check_b("b_line1", 0, 1, 12'h000);
        tick(127);
        check_b("b_last", 127, 1, 12'hFFF);
        tick(1);
        check("b_done", b_done, 1);
        check("b_done_dval", b_dval, 0);
        check("b_done_busy", b_busy, 1);
        tick(1);
        check_b("b_f2_first", 0, 0, 12'h000);
        b_pat = 2'd3;
        tick(64);
        check_b("b_f2_still_bars", 64, 0, 12'hFFF);
        tick(193);

        // Pattern 3 over two consecutive frames.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
`ifdef RAW_STREAM_GEN_LFSR_EN
                if (i < 4) check_b("p3_lfsr", i, 0, lfsr_exp[i]);
`else
                check_b("p3_checker", i, 0, (i < 8) ? 12'h000 : 12'hFFF);
`endif
                tick(1);
            end
            if (f == 1) b_cont = 1'b0;
            tick(240);
            check("p3_done", b_done, 1);
            tick(1);
        end
        check("p3_end_busy", b_busy, 0);
        check("p3_end_dval", b_dval, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
